// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared types and arithmetic helpers for the ANN layer controllers.
package neuron_mac_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int MULT_W = 8;

    // Wide enough for any practical accumulator; callers keep their own width <= SAT_W-1.
    localparam int SAT_W = 64;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] value;
    } sat_sum_t;

    // Unsigned add that clamps to 2^width-1 and flags the clamp.
    function automatic sat_sum_t sat_add(input logic [SAT_W-1:0]  acc,
                                         input logic [MULT_W-1:0] addend,
                                         input int unsigned       width);
        logic [SAT_W:0] total;
        logic [SAT_W:0] limit;
        sat_sum_t       r;
        total = {1'b0, acc} + {{(SAT_W + 1 - MULT_W){1'b0}}, addend};
        limit = ((SAT_W + 1)'(1) << width) - (SAT_W + 1)'(1);
        if (total > limit) begin
            r.sat   = 1'b1;
            r.value = limit[SAT_W-1:0];
        end else begin
            r.sat   = 1'b0;
            r.value = total[SAT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/neuron_mac_sequencer_if.sv
// Input/weight stream, result handshake and control for one neuron MAC sequencer.
interface neuron_mac_sequencer_if #(
    parameter int ACC_W = 12
);
    logic             start;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       x;
    logic [3:0]       w;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] sum;
    logic             overflow;
    logic             busy;

    modport master (
        output start, in_valid, x, w, out_ready,
        input  in_ready, out_valid, sum, overflow, busy
    );

    modport slave (
        input  start, in_valid, x, w, out_ready,
        output in_ready, out_valid, sum, overflow, busy
    );
endinterface

// File: rtl/neuron_mac_sequencer_multi4bit.sv
// Shared unsigned 4x4 -> 8 bit combinational multiplier.
module multi4bit
    import neuron_mac_sequencer_pkg::*;
(
    input  logic [3:0]        a,
    input  logic [3:0]        b,
    output logic [MULT_W-1:0] p
);
    assign p = {4'b0000, a} * {4'b0000, b};
endmodule

// File: rtl/neuron_mac_sequencer.sv
// Time-shares one 4x4 multiplier over N_INPUTS x/w pairs into a saturating accumulator.
//   state | meaning
//   IDLE  | waiting for start; sum holds last result
//   LOAD  | accepting pairs, one per cycle when in_valid
//   DRAIN | last product in flight, folded into acc on exit
//   DONE  | out_valid with stable sum/overflow until out_ready
module neuron_mac_sequencer
    import neuron_mac_sequencer_pkg::*;
#(
    parameter int N_INPUTS = 4,
    parameter int ACC_W    = 12
) (
    input logic                  clk,
    input logic                  rst,
    neuron_mac_sequencer_if.slave bus
);
    localparam int               CNT_W = $clog2(N_INPUTS) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(N_INPUTS - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [MULT_W-1:0]  prod_d;
    logic [MULT_W-1:0]  prod_q;
    logic               prod_v_q;
    logic [ACC_W-1:0]   acc_q;
    logic               ovf_q;

    logic               accept;
    logic               last_accept;
    logic               clear;
    sat_sum_t           acc_next;
    logic [ACC_W-1:0]   acc_sat_value;
    logic [SAT_W-ACC_W-1:0] acc_hi_unused;

    multi4bit u_mult (
        .a (bus.x),
        .b (bus.w),
        .p (prod_d)
    );

    assign accept      = (state_q == LOAD) && bus.in_valid;
    assign last_accept = accept && (cnt_q == LAST);
    assign clear       = (state_q == IDLE) && bus.start;

    assign acc_next = sat_add(SAT_W'(acc_q), prod_q, ACC_W);
    assign {acc_hi_unused, acc_sat_value} = acc_next.value;

    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.sum       = acc_q;
        bus.overflow  = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) state_d = LOAD;
            end
            LOAD: begin
                bus.in_ready = 1'b1;
                if (last_accept) state_d = DRAIN;
            end
            // The last product lands in acc on the same edge that leaves DRAIN.
            DRAIN: begin
                if (prod_v_q) state_d = DONE;
            end
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            prod_q   <= '0;
            prod_v_q <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prod_v_q <= accept;
            if (accept) prod_q <= prod_d;
            if (clear) begin
                cnt_q <= '0;
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                if (accept && !last_accept) cnt_q <= cnt_q + 1'b1;
                if (prod_v_q) begin
                    acc_q <= acc_sat_value;
                    if (acc_next.sat) ovf_q <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Bench for neuron_mac_sequencer: three configurations sharing one stimulus driver.
module tb_neuron_mac_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_d;
    logic       in_valid_d;
    logic       out_ready_d;
    logic [3:0] x_d;
    logic [3:0] w_d;
    int         sel;

    int checks = 0;
    int errors = 0;

    // a: N=4/ACC_W=12, b: N=4/ACC_W=8, c: N=1/ACC_W=12
    neuron_mac_sequencer_if #(.ACC_W(12)) bus_a ();
    neuron_mac_sequencer_if #(.ACC_W(8))  bus_b ();
    neuron_mac_sequencer_if #(.ACC_W(12)) bus_c ();

    neuron_mac_sequencer #(.N_INPUTS(4), .ACC_W(12)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    neuron_mac_sequencer #(.N_INPUTS(4), .ACC_W(8))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    neuron_mac_sequencer #(.N_INPUTS(1), .ACC_W(12)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

    assign bus_a.start     = start_d && (sel == 0);
    assign bus_b.start     = start_d && (sel == 1);
    assign bus_c.start     = start_d && (sel == 2);
    assign bus_a.in_valid  = in_valid_d && (sel == 0);
    assign bus_b.in_valid  = in_valid_d && (sel == 1);
    assign bus_c.in_valid  = in_valid_d && (sel == 2);
    assign bus_a.out_ready = out_ready_d && (sel == 0);
    assign bus_b.out_ready = out_ready_d && (sel == 1);
    assign bus_c.out_ready = out_ready_d && (sel == 2);
    assign bus_a.x = x_d;
    assign bus_b.x = x_d;
    assign bus_c.x = x_d;
    assign bus_a.w = w_d;
    assign bus_b.w = w_d;
    assign bus_c.w = w_d;

    logic        in_ready_m;
    logic        out_valid_m;
    logic        ovf_m;
    logic        busy_m;
    logic [11:0] sum_m;

    always_comb begin
        in_ready_m  = bus_c.in_ready;
        out_valid_m = bus_c.out_valid;
        ovf_m       = bus_c.overflow;
        busy_m      = bus_c.busy;
        sum_m       = bus_c.sum;
        case (sel)
            0: begin
                in_ready_m  = bus_a.in_ready;
                out_valid_m = bus_a.out_valid;
                ovf_m       = bus_a.overflow;
                busy_m      = bus_a.busy;
                sum_m       = bus_a.sum;
            end
            1: begin
                in_ready_m  = bus_b.in_ready;
                out_valid_m = bus_b.out_valid;
                ovf_m       = bus_b.overflow;
                busy_m      = bus_b.busy;
                sum_m       = {4'b0000, bus_b.sum};
            end
            default: ;
        endcase
    end

    typedef struct {
        int              sel;
        int              n;
        logic [3:0][3:0] xs;
        logic [3:0][3:0] ws;
        int              gap;
        int              bp;
        bit              poke;
        logic [11:0]     sum;
        logic            ovf;
        string           name;
    } vec_t;

    typedef struct {
        logic [11:0] sum;
        logic        ovf;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_eval(input vec_t v);
        int   budget;
        exp_t e;
        sel = v.sel;
        sb.push_back('{v.sum, v.ovf});
        if (v.poke) begin
            in_valid_d = 1'b1; x_d = 4'd15; w_d = 4'd15;
            repeat (2) begin
                step();
                chk({v.name, "/idle_in_ready"}, in_ready_m, 0);
            end
            in_valid_d = 1'b0;
        end
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        chk({v.name, "/load_in_ready"}, in_ready_m, 1);
        for (int i = 0; i < v.n; i++) begin
            if (i > 0) repeat (v.gap) step();
            in_valid_d = 1'b1; x_d = v.xs[i]; w_d = v.ws[i];
            if (v.poke && i == 1) start_d = 1'b1;
            budget = 0;
            while (!in_ready_m && budget < 50) begin
                step();
                budget++;
            end
            if (budget >= 50) chk({v.name, "/accept_timeout"}, 1, 0);
            step();
            in_valid_d = 1'b0;
            start_d    = 1'b0;
        end
        chk({v.name, "/drain_out_valid"}, out_valid_m, 0);
        chk({v.name, "/drain_in_ready"}, in_ready_m, 0);
        chk({v.name, "/drain_busy"}, busy_m, 1);
        if (v.poke) begin
            in_valid_d = 1'b1; x_d = 4'd15; w_d = 4'd15;
        end
        step();
        chk({v.name, "/done_out_valid"}, out_valid_m, 1);
        chk({v.name, "/done_in_ready"}, in_ready_m, 0);
        if (sb.size() == 0) begin
            chk({v.name, "/scoreboard_empty"}, 1, 0);
            e = '{12'd0, 1'b0};
        end else begin
            e = sb.pop_front();
        end
        chk({v.name, "/sum"}, sum_m, e.sum);
        chk({v.name, "/overflow"}, ovf_m, e.ovf);
        if (v.poke) start_d = 1'b1;
        repeat (v.bp) begin
            step();
            chk({v.name, "/bp_out_valid"}, out_valid_m, 1);
            chk({v.name, "/bp_sum"}, sum_m, e.sum);
        end
        start_d     = 1'b0;
        in_valid_d  = 1'b0;
        out_ready_d = 1'b1;
        step();
        out_ready_d = 1'b0;
        chk({v.name, "/idle_busy"}, busy_m, 0);
        chk({v.name, "/idle_out_valid"}, out_valid_m, 0);
        chk({v.name, "/idle_in_ready_after"}, in_ready_m, 0);
    endtask

    initial begin
        vec_t rv;
        // Pair lists are written last-first: {p3, p2, p1, p0}.
        vecs[0] = '{0, 4, {4'd7, 4'd0, 4'd15, 4'd3}, {4'd2, 4'd9, 4'd15, 4'd5},
                    0, 0, 1'b0, 12'd254, 1'b0, "basic"};
        vecs[1] = '{1, 4, {4'd15, 4'd15, 4'd15, 4'd15}, {4'd15, 4'd15, 4'd15, 4'd15},
                    0, 0, 1'b0, 12'd255, 1'b1, "saturate"};
        vecs[2] = '{0, 4, {4'd4, 4'd3, 4'd2, 4'd1}, {4'd4, 4'd3, 4'd2, 4'd1},
                    2, 5, 1'b0, 12'd30, 1'b0, "stall_bp"};
        vecs[3] = '{0, 4, {4'd7, 4'd5, 4'd3, 4'd1}, {4'd8, 4'd6, 4'd4, 4'd2},
                    0, 2, 1'b1, 12'd100, 1'b0, "ignored"};
        vecs[4] = '{2, 1, {4'd0, 4'd0, 4'd0, 4'd15}, {4'd0, 4'd0, 4'd0, 4'd15},
                    0, 0, 1'b0, 12'd225, 1'b0, "single"};
        vecs[5] = '{1, 4, {4'd8, 4'd6, 4'd4, 4'd2}, {4'd9, 4'd7, 4'd5, 4'd3},
                    1, 1, 1'b0, 12'd140, 1'b0, "acc8_nosat"};

        rst = 1'b1; start_d = 1'b0; in_valid_d = 1'b0; out_ready_d = 1'b0;
        x_d = 4'd0; w_d = 4'd0; sel = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            chk("reset_in_ready", in_ready_m, 0);
            chk("reset_out_valid", out_valid_m, 0);
            chk("reset_sum", sum_m, 0);
            chk("reset_overflow", ovf_m, 0);
            chk("reset_busy", busy_m, 0);
        end
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_eval(vecs[i]);

        // Reset with two pairs accepted and the second product still in flight.
        sel = 0;
        start_d = 1'b1;
        step();
        start_d = 1'b0;
        in_valid_d = 1'b1; x_d = 4'd5; w_d = 4'd5;
        step();
        x_d = 4'd6; w_d = 4'd6;
        step();
        in_valid_d = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_busy", busy_m, 0);
        chk("midrst_in_ready", in_ready_m, 0);
        chk("midrst_out_valid", out_valid_m, 0);
        chk("midrst_sum", sum_m, 0);
        chk("midrst_overflow", ovf_m, 0);
        step();
        chk("midrst_sum_settled", sum_m, 0);
        chk("midrst_still_idle", busy_m, 0);

        rv = '{0, 4, {4'd2, 4'd2, 4'd2, 4'd2}, {4'd3, 4'd3, 4'd3, 4'd3},
               0, 0, 1'b0, 12'd24, 1'b0, "after_reset"};
        run_eval(rv);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Sequential multiply-accumulate controller for one neuron of the ANN datapath. It time-shares a single unsigned 4×4→8-bit multiplier across N input/weight pairs that arrive on a valid/ready stream. It accumulates the products into a saturating accumulator and presents the neuron's pre-activation sum on an output handshake. It sits between the layer's input/weight feeder and the activation stage.

## Interface

Parameters:
- N_INPUTS, 4, number of input/weight pairs per neuron evaluation (1..64)
- ACC_W, 12, accumulator/sum width; must be ≥ 8

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset; one clock, reset is synchronous and active-high
- start  input  1  begin a new evaluation; sampled only in IDLE
- in_valid  input  1  x/w pair valid
- in_ready  output  1  block accepts a pair this cycle
- x  input  4  unsigned neuron input
- w  input  4  unsigned weight
- out_valid  output  1  sum valid
- out_ready  input  1  downstream accepts sum
- sum  output  ACC_W  accumulated result
- overflow  output  1  accumulator saturated during this evaluation; valid with out_valid
- busy  output  1  high in any state other than IDLE

## Operation

- States:
  - IDLE: start=1 → LOAD. The accumulator, pair counter and overflow clear on that edge.
  - LOAD: in_ready=1. A pair is accepted when in_valid&&in_ready. After the N_INPUTS-th accept → DRAIN.
  - DRAIN: in_ready=0. Waits until the last product is accumulated → DONE.
  - DONE: out_valid=1, sum/overflow held stable. out_valid&&out_ready → IDLE.
- Datapath:
  - Accepted x*w goes through the multiplier, combinational 8-bit.
  - The result is registered into prod_q with a prod_v flag.
  - Next cycle, prod_q is zero-extended and added to acc.
- Arithmetic:
  - Unsigned throughout.
  - If acc + prod_q > 2^ACC_W−1, acc becomes all-ones and overflow latches to 1 until the next start.
- start outside IDLE is ignored. in_valid outside LOAD is ignored and has no effect.
- The pair counter counts 0..N_INPUTS−1, with width clog2(N_INPUTS)+1. It never wraps within an evaluation.
- rst in any state, including mid-LOAD with a product in flight:
  - next state is IDLE
  - acc, prod_q, prod_v, counter and overflow clear
  - the partial sum is discarded
- Reset values: in_ready=0, out_valid=0, sum=0, overflow=0, busy=0.

## Timing

- start sampled at edge E0 → LOAD during cycle E0+1; in_ready is high in that cycle.
- Back-to-back accepts are allowed, one pair per cycle with no bubbles. in_valid gaps simply stall.
- Pair accepted at edge T → prod_q valid in cycle T+1 → acc updated at edge T+2.
- Last pair accepted at edge T → DRAIN in cycle T+1 → DONE with out_valid=1 in cycle T+2.
- Minimum evaluation: 1 (start) + N_INPUTS + 2 cycles to out_valid.
- out_valid held with stable sum while out_ready=0. After the handshake edge the block is in IDLE, and start is accepted on the following edge.
- The final accumulation and the DRAIN→DONE transition occur on the same edge, so there is no extra cycle.

## Structure

- Shared package holds:
  - the state enum: IDLE, LOAD, DRAIN, DONE
  - the constant MULT_W=8
  - the saturating-add function (used by later layer controllers)
- One sub-module: the existing Multi4bit, instantiated once as the shared multiplier.
- The FSM, counter, product register and accumulator are in this block.

## Test plan

- Basic sum, N=4, ACC_W=12, pairs (3,5),(15,15),(0,9),(7,2) back-to-back → sum=254, overflow=0, out_valid 2 cycles after 4th accept.
- Saturation, N=4, ACC_W=8, four pairs of (15,15) → sum=255, overflow=1.
- Input stalls and output backpressure:
  - in_valid toggled 1,0,0,1,… with pairs (1,1),(2,2),(3,3),(4,4) → sum=30.
  - out_ready held low 5 cycles → out_valid and sum=30 stable throughout, IDLE one edge after out_ready=1.
- Ignored controls: start pulsed during LOAD and DONE, in_valid high in IDLE/DRAIN → no extra accepts, sum unchanged, in_ready=0 outside LOAD.
- Reset mid-operation:
  - rst after 2 of 4 pairs, with a product in flight → IDLE, all outputs 0.
  - New evaluation of (2,3)×4 → sum=24, overflow=0.
- N_INPUTS=1 corner: single pair (15,15) → sum=225, out_valid exactly 2 cycles after accept.
